// File: rtl/key_debounce.sv
// Debounces one active-low pushbutton into a clean level plus press/release pulses.
// Optional auto-repeat while held is built only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce #(
    parameter int STABLE_TICKS  = 16,
    parameter int CNT_W         = 8,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16,
    parameter int REP_W         = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CE,
    input  logic KEY_N,
    output logic LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic REPEAT
);

    // state         | meaning
    // RELEASED      | key accepted as up, LEVEL=0
    // PRESS_PEND    | key seen down, counting CE ticks of stability, LEVEL=0
    // PRESSED       | key accepted as down, LEVEL=1
    // RELEASE_PEND  | key seen up, counting CE ticks of stability, LEVEL=1
    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_PEND,
        ST_PRESSED,
        ST_RELEASE_PEND
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            state   <= ST_RELEASED;
            cnt     <= '0;
            LEVEL   <= 1'b0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
        end else begin
            sync1   <= ~KEY_N;
            sync2   <= sync1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            LEVEL   <= level_nxt;
            PRESS   <= press_nxt;
            RELEASE <= release_nxt;
        end
    end

    // A change of the synchronised key always wins over a CE tick in the same cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_RELEASED: begin
                if (sync2) begin
                    state_nxt = ST_PRESS_PEND;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS_PEND: begin
                if (!sync2) begin
                    state_nxt = ST_RELEASED;
                end else if (CE) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_PRESSED;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_PRESSED: begin
                if (!sync2) begin
                    state_nxt = ST_RELEASE_PEND;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE_PEND: begin
                if (sync2) begin
                    state_nxt = ST_PRESSED;
                end else if (CE) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt   = ST_RELEASED;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
                cnt_nxt   = '0;
            end
        endcase
        level_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_PEND);
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic             rep_periodic;
    logic             rep_periodic_nxt;
    logic             repeat_nxt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rep_cnt      <= '0;
            rep_periodic <= 1'b0;
            REPEAT       <= 1'b0;
        end else begin
            rep_cnt      <= rep_cnt_nxt;
            rep_periodic <= rep_periodic_nxt;
            REPEAT       <= repeat_nxt;
        end
    end

    // rep_periodic selects the reload target: initial delay first, then the period.
    always_comb begin
        rep_cnt_nxt      = rep_cnt;
        rep_periodic_nxt = rep_periodic;
        repeat_nxt       = 1'b0;
        if (state == ST_PRESS_PEND && state_nxt == ST_PRESSED) begin
            rep_cnt_nxt      = '0;
            rep_periodic_nxt = 1'b0;
        end else if (state == ST_PRESSED && state_nxt == ST_PRESSED && CE) begin
            if (rep_cnt == (rep_periodic ? PERIOD_LAST : DELAY_LAST)) begin
                repeat_nxt       = 1'b1;
                rep_cnt_nxt      = '0;
                rep_periodic_nxt = 1'b1;
            end else begin
                rep_cnt_nxt = rep_cnt + REP_W'(1);
            end
        end else if (state_nxt == ST_RELEASED) begin
            rep_cnt_nxt      = '0;
            rep_periodic_nxt = 1'b0;
        end
    end
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, REP_W};
    assign REPEAT         = 1'b0;
`endif

endmodule
